vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator that sits directly upstream of `screen_design`. It produces the 640x480@60 Hz VGA horizontal/vertical sync pulses, the active-video qualifier and the current pixel coordinates. `screen_design` consumes these to drive `r_out/g_out/b_out`. All outputs are registered and mutually aligned, so the colour stage needs no extra delay matching.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `h_sync`/`v_sync` (0 = active-low)
- `clk` in 1: the single clock. All state is in this domain.
- `rst` in 1: reset, synchronous, active-high.
- `pix_en` out 1: one-`clk` strobe marking the cycle in which new pixel outputs appear.
- `h_sync` out 1: horizontal sync at `SYNC_POL`.
- `v_sync` out 1: vertical sync at `SYNC_POL`.
- `video_on` out 1: high while the pixel is inside the visible area.
- `pix_x` out 10: horizontal count, 0..H_TOTAL-1.
- `pix_y` out 10: vertical count, 0..V_TOTAL-1.
- `line_start` out 1: one-`clk` pulse on the update where `pix_x`=0.
- `frame_start` out 1: one-`clk` pulse on the update where `pix_x`=0 and `pix_y`=0.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525. Counters are 10 bits unsigned. The parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.
- Internal `tick` advances the raster. Its source is set by the macro in Configuration.
- `h_cnt` and `v_cnt` update only on `tick`:
  - `h_cnt` counts 0..799. At 799 it wraps to 0 and `v_cnt` increments.
  - `v_cnt` counts 0..524. At `v_cnt`=524 with `h_cnt`=799, both counters wrap to 0.
- Horizontal phase FSM, advancing on `tick`:
  - H_ACT (h 0..639) → H_FP at h=639.
  - H_FP (640..655) → H_SYN at h=655.
  - H_SYN (656..751) → H_BP at h=751.
  - H_BP (752..799) → H_ACT at h=799.
  - Reset state is H_ACT.
- `h_sync` is asserted when the FSM is in H_SYN.
- `v_sync` is asserted for `v_cnt` in 490..491.
- `video_on` = (FSM==H_ACT) && `v_cnt` < 480.
- Output register stage, on each `tick`:
  - Decode the current counts into all outputs.
  - Then advance the counters.
  - Between ticks, the level outputs hold their values.
  - `pix_en`, `line_start` and `frame_start` are low on every `clk` without a tick.
- Reset mid-frame: the same `clk` edge returns the counters, FSM, divider and outputs to their reset values. No partial line is completed.

## Timing
- Reset values:
  - `h_sync` = `v_sync` = ~SYNC_POL (deasserted).
  - `video_on` = 0, `pix_x` = 0, `pix_y` = 0.
  - `pix_en` = `line_start` = `frame_start` = 0.
- Latency is 1 `clk` from `tick` to output. All outputs change on the same edge, together with the `pix_en` high.
- First update after `rst` falls:
  - `pix_x`=0, `pix_y`=0.
  - `video_on`=1, `line_start`=1, `frame_start`=1.
- Frame length is 420000 ticks.

## Configuration
- Macro `VGA_PIXEL_DIV_EN`.
  - When defined: a divide-by-4 prescaler generates `tick` on every 4th `clk` (100 MHz board clock → 25 MHz pixel rate). The divider resets to 0, so the first tick falls on the 4th `clk` after `rst` deasserts.
  - When undefined: `tick` = 1 on every `clk`, because `clk` is already the pixel clock. The first update is on the 1st `clk` after reset.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL and V_TOTAL;
  - the horizontal FSM state enum.
- Sub-module `vga_pixel_tick` contains the prescaler. It is instantiated only under `VGA_PIXEL_DIV_EN`.

## Test plan
- Hold `rst` high for 5 clk → all outputs stay at their reset values. Release → first `pix_en` has `frame_start`=1, `line_start`=1, (`pix_x`,`pix_y`)=(0,0), `video_on`=1.
- Run one line → `h_sync` asserted for exactly 96 consecutive updates, `pix_x` 656..751. `video_on` falls at `pix_x`=640.
- Line wrap: update after `pix_x`=799 on `pix_y`=10 → `pix_x`=0, `pix_y`=11, `line_start`=1, `frame_start`=0.
- Frame wrap: update after (799,524) → (0,0) with `frame_start`=1. `v_sync` asserted only for `pix_y` 490..491, i.e. exactly 1600 updates.
- Assert `rst` for 1 clk at (300,200) → next edge gives reset values. The first update after release is (0,0) with `frame_start`=1.
- With `VGA_PIXEL_DIV_EN` defined → `pix_en` period is 4 clk and a frame is 1,680,000 clk. Undefined → `pix_en` is constantly high and a frame is 420,000 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Default 640x480@60 raster constants and horizontal phase encoding.
// Rev     : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W        = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        ST_H_ACT = 2'd0,
        ST_H_FP  = 2'd1,
        ST_H_SYN = 2'd2,
        ST_H_BP  = 2'd3
    } h_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen_if
// Brief   : Raster timing bundle from the sync generator to the colour stage.
// Rev     : 1.0  initial release
// ============================================================================
interface vga_sync_gen_if;

    logic                                pix_en;
    logic                                h_sync;
    logic                                v_sync;
    logic                                video_on;
    logic [vga_timing_pkg::CNT_W-1:0]    pix_x;
    logic [vga_timing_pkg::CNT_W-1:0]    pix_y;
    logic                                line_start;
    logic                                frame_start;

    modport master (
        output pix_en, h_sync, v_sync, video_on, pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input  pix_en, h_sync, v_sync, video_on, pix_x, pix_y, line_start, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_tick
// Brief   : Clock prescaler; tick is high on every DIV-th clk after reset.
// Rev     : 1.0  initial release
// ============================================================================
module vga_pixel_tick #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        tick  = (div_q == DIV_W'(DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen
// Brief   : VGA raster timing generator with registered, mutually aligned
//           sync / video / coordinate outputs. Define VGA_PIXEL_DIV_EN to
//           derive the pixel tick from a divide-by-4 prescaler.
// Rev     : 1.0  initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vga_sync_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_SYN_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_LINES = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYN_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYN_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic tick;

`ifdef VGA_PIXEL_DIV_EN
    vga_pixel_tick #(
        .DIV  (4)
    ) u_pixel_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    h_state_e           h_state_q, h_state_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;

    logic               pix_en_q, pix_en_d;
    logic               h_sync_q, h_sync_d;
    logic               v_sync_q, v_sync_d;
    logic               video_on_q, video_on_d;
    logic [CNT_W-1:0]   pix_x_q, pix_x_d;
    logic [CNT_W-1:0]   pix_y_q, pix_y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    // Horizontal phase tracks h_cnt; transitions occur on the last count of each phase.
    always_comb begin
        h_state_d = h_state_q;
        if (tick) begin
            case (h_state_q)
                ST_H_ACT: if (h_cnt_q == H_ACT_LAST) h_state_d = ST_H_FP;
                ST_H_FP:  if (h_cnt_q == H_FP_LAST)  h_state_d = ST_H_SYN;
                ST_H_SYN: if (h_cnt_q == H_SYN_LAST) h_state_d = ST_H_BP;
                ST_H_BP:  if (h_cnt_q == H_LAST)     h_state_d = ST_H_ACT;
                default:                             h_state_d = ST_H_ACT;
            endcase
        end
    end

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_en_d      = 1'b0;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        video_on_d    = video_on_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (tick) begin
            // Outputs describe the counts as they stand before this tick advances them.
            pix_en_d      = 1'b1;
            pix_x_d       = h_cnt_q;
            pix_y_d       = v_cnt_q;
            h_sync_d      = (h_state_q == ST_H_SYN) ? SYNC_POL : ~SYNC_POL;
            v_sync_d      = (v_cnt_q >= V_SYN_FIRST && v_cnt_q <= V_SYN_LAST) ? SYNC_POL : ~SYNC_POL;
            video_on_d    = (h_state_q == ST_H_ACT) && (v_cnt_q < V_VIS_LINES);
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_state_q     <= ST_H_ACT;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_en_q      <= 1'b0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_en_q      <= pix_en_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sync_gen
// Brief   : Self-checking bench for vga_sync_gen (full horizontal timing, short
//           vertical timing so a whole frame fits in a short run).
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int VA = 12,  VF = 2,  VS = 2,  VB = 2,  VT = 18;
    localparam logic POL = 1'b0;
`ifdef VGA_PIXEL_DIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    bit armed    = 1'b0;
    bit abort    = 1'b0;

    // Number of non-reset clk edges since the last reset edge.
    always @(posedge clk) begin
        if (rst) begin
            edges <= 0;
            armed <= 1'b1;
        end else begin
            edges <= edges + 1;
        end
    end

    // Expected output bundle after k non-reset edges, straight from the raster rules.
    function automatic logic [26:0] model(int k);
        int  n, x, y;
        logic pe, hs, vs, vo, ls, fs;
        pe = (k > 0) && (k % DIV == 0);
        n  = k / DIV - 1;
        if (n < 0) return {1'b0, ~POL, ~POL, 1'b0, 10'd0, 10'd0, 2'b00};
        x  = n % HT;
        y  = (n / HT) % VT;
        hs = (x >= HA + HF && x < HA + HF + HS) ? POL : ~POL;
        vs = (y >= VA + VF && y < VA + VF + VS) ? POL : ~POL;
        vo = (x < HA) && (y < VA);
        ls = pe && (x == 0);
        fs = ls && (y == 0);
        return {pe, hs, vs, vo, 10'(x), 10'(y), ls, fs};
    endfunction

    function automatic logic [26:0] actual();
        return {vif.pix_en, vif.h_sync, vif.v_sync, vif.video_on,
                vif.pix_x, vif.pix_y, vif.line_start, vif.frame_start};
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            logic [26:0] exp_v;
            exp_v = model(edges);
            checks++;
            if (actual() !== exp_v) begin
                failures++;
                $display("FAIL model_cmp t=%0t edges=%0d actual=%h required=%h", $time, edges, actual(), exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic next_update(output int clks);
        clks = 0;
        if (abort) return;
        do begin
            @(negedge clk);
            clks++;
        end while (!vif.pix_en && clks < DIV + 4);
        if (!vif.pix_en) begin
            chk("update_timeout", 0, 1);
            abort = 1'b1;
        end
    endtask

    localparam logic [26:0] RESET_VEC = {1'b0, ~POL, ~POL, 1'b0, 10'd0, 10'd0, 2'b00};

    initial begin
        int c, px, py;
        int hs_cnt, hs_min, hs_max, vid_fall;
        int vs_cnt, vs_ymin, vs_ymax;
        int per_min, per_max, frame_clk;
        bit wrap_seen, reached;

        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("reset_hold", int'(actual()), int'(RESET_VEC));
        end
        rst = 1'b0;

        next_update(c);
        chk("first_latency", c, DIV);
        chk("first_pix_x", int'(vif.pix_x), 0);
        chk("first_pix_y", int'(vif.pix_y), 0);
        chk("first_video_on", int'(vif.video_on), 1);
        chk("first_line_start", int'(vif.line_start), 1);
        chk("first_frame_start", int'(vif.frame_start), 1);

        hs_cnt = 0; hs_min = 9999; hs_max = -1; vid_fall = -1;
        vs_cnt = 0; vs_ymin = 9999; vs_ymax = -1;
        per_min = 9999; per_max = 0; frame_clk = 0; wrap_seen = 1'b0;
        px = 0; py = 0;
        for (int n = 1; n <= HT * VT && !abort; n++) begin
            px = int'(vif.pix_x);
            py = int'(vif.pix_y);
            next_update(c);
            frame_clk += c;
            if (c < per_min) per_min = c;
            if (c > per_max) per_max = c;
            if (n < HT) begin
                if (vif.h_sync == POL) begin
                    hs_cnt++;
                    if (int'(vif.pix_x) < hs_min) hs_min = int'(vif.pix_x);
                    if (int'(vif.pix_x) > hs_max) hs_max = int'(vif.pix_x);
                end
                if (vid_fall < 0 && !vif.video_on) vid_fall = int'(vif.pix_x);
            end
            if (px == HT - 1 && py == 10) begin
                wrap_seen = 1'b1;
                chk("line_wrap_x", int'(vif.pix_x), 0);
                chk("line_wrap_y", int'(vif.pix_y), 11);
                chk("line_wrap_ls", int'(vif.line_start), 1);
                chk("line_wrap_fs", int'(vif.frame_start), 0);
            end
            if (n < HT * VT && vif.v_sync == POL) begin
                vs_cnt++;
                if (int'(vif.pix_y) < vs_ymin) vs_ymin = int'(vif.pix_y);
                if (int'(vif.pix_y) > vs_ymax) vs_ymax = int'(vif.pix_y);
            end
        end

        if (!abort) begin
            chk("line_wrap_seen", int'(wrap_seen), 1);
            chk("hsync_count", hs_cnt, 96);
            chk("hsync_first_x", hs_min, 656);
            chk("hsync_last_x", hs_max, 751);
            chk("video_fall_x", vid_fall, 640);
            chk("vsync_count", vs_cnt, 1600);
            chk("vsync_first_y", vs_ymin, 14);
            chk("vsync_last_y", vs_ymax, 15);
            chk("frame_wrap_prev_x", px, 799);
            chk("frame_wrap_prev_y", py, 17);
            chk("frame_wrap_x", int'(vif.pix_x), 0);
            chk("frame_wrap_y", int'(vif.pix_y), 0);
            chk("frame_wrap_fs", int'(vif.frame_start), 1);
            chk("frame_clks", frame_clk, HT * VT * DIV);
            chk("pix_en_period_min", per_min, DIV);
            chk("pix_en_period_max", per_max, DIV);
        end

        reached = 1'b0;
        for (int i = 0; i < HT * 8 && !abort; i++) begin
            next_update(c);
            if (vif.pix_x == 10'd300 && vif.pix_y == 10'd5) begin
                reached = 1'b1;
                break;
            end
        end
        if (!abort) begin
            chk("midframe_reached", int'(reached), 1);
            rst = 1'b1;
            @(negedge clk);
            chk("midframe_reset_vals", int'(actual()), int'(RESET_VEC));
            rst = 1'b0;
            next_update(c);
            if (!abort) begin
                chk("post_reset_latency", c, DIV);
                chk("post_reset_x", int'(vif.pix_x), 0);
                chk("post_reset_y", int'(vif.pix_y), 0);
                chk("post_reset_fs", int'(vif.frame_start), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
